// File: rtl/dac_pkg.sv
// Shared constants for the DAC sample generator slice:
// code width, pacer width, waveform mode encoding and ramp direction.
package dac_pkg;

  localparam int DAC_DATA_W = 12;
  localparam int DAC_PER_W  = 16;

  localparam logic [1:0] MODE_CONST    = 2'd0;
  localparam logic [1:0] MODE_RAMP     = 2'd1;
  localparam logic [1:0] MODE_SQUARE   = 2'd2;
  localparam logic [1:0] MODE_TRIANGLE = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/dac_rate_tick.sv
// Sample pacer: counts 0..period-1 while enabled and emits a
// registered one-cycle tick each time the count wraps to zero.
module dac_rate_tick
  import dac_pkg::*;
#(
  parameter int PER_W = DAC_PER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] last;
  logic             tick_q, tick_d;

  always_comb begin
    last   = (period == '0) ? '0 : period - PER_W'(1);
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q >= last) begin
      // >= lets a shortened period wrap at once
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + PER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q & enable;

endmodule

// File: rtl/dac_sample_gen.sv
// Paced waveform sample source for a DAC serializer (valid/ready out).
// Define DAC_SAMPLE_GEN_TRIANGLE_EN to give mode 3 a true triangle.
module dac_sample_gen
  import dac_pkg::*;
#(
  parameter int DATA_W = DAC_DATA_W,
  parameter int PER_W  = DAC_PER_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] step,
  input  logic [PER_W-1:0]  period,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  logic              tick;
  logic              pending;
  logic              xfer;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              phase_q, phase_d;
`ifdef DAC_SAMPLE_GEN_TRIANGLE_EN
  localparam logic [DATA_W-1:0] CODE_MAX = '1;
  dir_e              dir_q, dir_d;
  logic [DATA_W:0]   sum_up;
`endif

  dac_rate_tick #(
    .PER_W (PER_W)
  ) u_rate_tick (
    .clk    (clk),
    .rst_n  (reset),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    data_d  = data_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    phase_d = phase_q;
`ifdef DAC_SAMPLE_GEN_TRIANGLE_EN
    dir_d   = dir_q;
    sum_up  = {1'b0, acc_q} + {1'b0, step};
`endif
    pending = valid_q & ~sample_ready;
    xfer    = valid_q & sample_ready;
    if (tick && !pending) begin
      valid_d = 1'b1;
      unique case (mode)
        MODE_CONST: begin
          data_d = step;
        end
        MODE_RAMP: begin
          data_d = acc_q;
          acc_d  = acc_q + step;
        end
        MODE_SQUARE: begin
          phase_d = ~phase_q;
          data_d  = phase_q ? '0 : step;
        end
`ifdef DAC_SAMPLE_GEN_TRIANGLE_EN
        MODE_TRIANGLE: begin
          data_d = acc_q;
          if (dir_q == DIR_UP) begin
            if (sum_up >= {1'b0, CODE_MAX}) begin
              acc_d = CODE_MAX;
              dir_d = DIR_DOWN;
            end else begin
              acc_d = sum_up[DATA_W-1:0];
            end
          end else begin
            if (acc_q <= step) begin
              acc_d = '0;
              dir_d = DIR_UP;
            end else begin
              acc_d = acc_q - step;
            end
          end
        end
`else
        MODE_TRIANGLE: begin
          data_d = acc_q;
          acc_d  = acc_q + step;
        end
`endif
      endcase
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    // a fresh overrun outranks a clear in the same cycle
    ovr_d = (ovr_q & ~clr_overrun) | (tick & pending);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      phase_q <= phase_d;
    end
  end

`ifdef DAC_SAMPLE_GEN_TRIANGLE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule
